// File: rtl/ifu_fb_pkg.sv
// Shared defaults and entry types for the instruction-fetch buffer.
// Holds the fetch-buffer depth/width defaults and the stored entry layout.
package ifu_fb_pkg;

    localparam int FB_DEPTH_DEF = 4;
    localparam int FB_DW_DEF    = 64;
    localparam int FB_AW        = 31;

    // Side-band information kept with every fetch block.
    typedef struct packed {
        logic [FB_AW-1:0] addr;
        logic             fault;
    } fb_meta_t;

    // Full entry at the default data width.
    typedef struct packed {
        logic [FB_DW_DEF-1:0] data;
        logic [FB_AW-1:0]     addr;
        logic                 fault;
    } fb_entry_t;

endpackage

// File: rtl/ifu_fb_mem.sv
// Fetch-buffer storage: one write port, two combinational read ports (head and head+1).
// Storage is deliberately not reset; validity is tracked by the controller.
module ifu_fb_mem
    import ifu_fb_pkg::*;
#(
    parameter int FB_DEPTH = FB_DEPTH_DEF,
    parameter int FB_DW    = FB_DW_DEF,
    localparam int PW      = $clog2(FB_DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PW-1:0]    wr_ptr,
    input  logic [FB_DW-1:0] wr_data,
    input  fb_meta_t         wr_meta,
    input  logic [PW-1:0]    rd_ptr,
    output logic [FB_DW-1:0] rd0_data,
    output fb_meta_t         rd0_meta,
    output logic [FB_DW-1:0] rd1_data,
    output fb_meta_t         rd1_meta
);

    logic [FB_DW-1:0] data_q [FB_DEPTH];
    fb_meta_t         meta_q [FB_DEPTH];
    logic [PW-1:0]    rd1_ptr;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[wr_ptr] <= wr_data;
            meta_q[wr_ptr] <= wr_meta;
        end
    end

    assign rd1_ptr  = rd_ptr + PW'(1);
    assign rd0_data = data_q[rd_ptr];
    assign rd0_meta = meta_q[rd_ptr];
    assign rd1_data = data_q[rd1_ptr];
    assign rd1_meta = meta_q[rd1_ptr];

endmodule

// File: rtl/ifu_fb_ctl.sv
// Fetch-buffer controller: circular FIFO between F2 fetch and the aligner,
// presenting the two oldest blocks and reporting how many the aligner removed.
module ifu_fb_ctl
    import ifu_fb_pkg::*;
#(
    parameter int FB_DEPTH = FB_DEPTH_DEF,
    parameter int FB_DW    = FB_DW_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        fetch_valid_f2,
    input  logic [30:0]                 fetch_addr_f2,
    input  logic [FB_DW-1:0]            fetch_data_f2,
    input  logic                        fetch_fault_f2,
    input  logic                        exu_flush_final,
    input  logic                        align_pop1,
    input  logic                        align_pop2,
    output logic [1:0]                  fb_valid,
    output logic [FB_DW-1:0]            fb0_data,
    output logic [FB_DW-1:0]            fb1_data,
    output logic [30:0]                 fb0_addr,
    output logic [30:0]                 fb1_addr,
    output logic                        fb0_fault,
    output logic                        fb1_fault,
    output logic                        ifu_fb_consume1,
    output logic                        ifu_fb_consume2,
    output logic [$clog2(FB_DEPTH):0]   fb_count,
    output logic                        fb_full,
    output logic                        fb_overflow
);

    localparam int PW = $clog2(FB_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] ZERO = CW'(0);
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] TWO  = CW'(2);
    localparam logic [CW-1:0] FULL = CW'(FB_DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic          pop1_req, pop2_req;
    logic          consume1, consume2;
    logic [CW-1:0] consumed;
    logic          full;
    logic          wr_en;
    fb_meta_t      wr_meta, rd0_meta, rd1_meta;

    assign full = (count_q == FULL);

    // Both pop lines together mean "take two"; a lone pop1 means "take one".
    always_comb begin
        pop2_req = align_pop2;
        pop1_req = align_pop1 & ~align_pop2;
        consume2 = ~exu_flush_final & pop2_req & (count_q >= TWO);
        consume1 = ~exu_flush_final &
                   ((pop2_req & (count_q == ONE)) | (pop1_req & (count_q != ZERO)));
        consumed = ZERO;
        if (consume2) begin
            consumed = TWO;
        end else if (consume1) begin
            consumed = ONE;
        end
        wr_en = fetch_valid_f2 & ~exu_flush_final & (~full | consume1 | consume2);
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (exu_flush_final) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = ZERO;
        end else begin
            wr_ptr_d = wr_ptr_q + PW'(wr_en);
            rd_ptr_d = rd_ptr_q + PW'(consumed);
            count_d  = count_q + CW'(wr_en) - consumed;
            if (fetch_valid_f2 & full & ~consume1 & ~consume2) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= ZERO;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign wr_meta.addr  = fetch_addr_f2;
    assign wr_meta.fault = fetch_fault_f2;

    ifu_fb_mem #(
        .FB_DEPTH (FB_DEPTH),
        .FB_DW    (FB_DW)
    ) u_mem (
        .clk      (clk),
        .wr_en    (wr_en),
        .wr_ptr   (wr_ptr_q),
        .wr_data  (fetch_data_f2),
        .wr_meta  (wr_meta),
        .rd_ptr   (rd_ptr_q),
        .rd0_data (fb0_data),
        .rd0_meta (rd0_meta),
        .rd1_data (fb1_data),
        .rd1_meta (rd1_meta)
    );

    assign fb0_addr        = rd0_meta.addr;
    assign fb0_fault       = rd0_meta.fault;
    assign fb1_addr        = rd1_meta.addr;
    assign fb1_fault       = rd1_meta.fault;
    assign fb_valid        = {count_q >= TWO, count_q != ZERO};
    assign fb_count        = count_q;
    assign fb_full         = full;
    assign fb_overflow     = overflow_q;
    assign ifu_fb_consume1 = consume1;
    assign ifu_fb_consume2 = consume2;

endmodule

// File: tb/tb_ifu_fb_ctl.sv
// Self-checking bench for ifu_fb_ctl: directed table, corner-case sequences,
// and randomized traffic against a queue-based reference model.
module tb_ifu_fb_ctl;

    localparam int DEPTH = 4;
    localparam int DW    = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          fetch_valid_f2 = 1'b0;
    logic [30:0]   fetch_addr_f2 = '0;
    logic [DW-1:0] fetch_data_f2 = '0;
    logic          fetch_fault_f2 = 1'b0;
    logic          exu_flush_final = 1'b0;
    logic          align_pop1 = 1'b0;
    logic          align_pop2 = 1'b0;
    logic [1:0]    fb_valid;
    logic [DW-1:0] fb0_data, fb1_data;
    logic [30:0]   fb0_addr, fb1_addr;
    logic          fb0_fault, fb1_fault;
    logic          ifu_fb_consume1, ifu_fb_consume2;
    logic [2:0]    fb_count;
    logic          fb_full, fb_overflow;

    int vectors = 0;
    int miscompares = 0;

    ifu_fb_ctl #(.FB_DEPTH(DEPTH), .FB_DW(DW)) dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_valid_f2  (fetch_valid_f2),
        .fetch_addr_f2   (fetch_addr_f2),
        .fetch_data_f2   (fetch_data_f2),
        .fetch_fault_f2  (fetch_fault_f2),
        .exu_flush_final (exu_flush_final),
        .align_pop1      (align_pop1),
        .align_pop2      (align_pop2),
        .fb_valid        (fb_valid),
        .fb0_data        (fb0_data),
        .fb1_data        (fb1_data),
        .fb0_addr        (fb0_addr),
        .fb1_addr        (fb1_addr),
        .fb0_fault       (fb0_fault),
        .fb1_fault       (fb1_fault),
        .ifu_fb_consume1 (ifu_fb_consume1),
        .ifu_fb_consume2 (ifu_fb_consume2),
        .fb_count        (fb_count),
        .fb_full         (fb_full),
        .fb_overflow     (fb_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [30:0] addr;
        logic        fault;
    } ent_t;

    ent_t mq[$];
    bit   movf = 1'b0;

    typedef struct {
        bit          fv;
        logic [30:0] addr;
        bit          p1, p2, fl;
        int          e_cnt;
        int          e_vld;
        bit          e_c1, e_c2, e_full, e_ovf;
        bit          ca0;
        logic [30:0] e_a0;
    } vec_t;

    vec_t tbl[19];

    function automatic logic [63:0] data_of(input logic [30:0] a);
        return {a, 1'b1, ~a, 1'b0};
    endfunction

    function automatic logic fault_of(input logic [30:0] a);
        return a[3] ^ a[4];
    endfunction

    function automatic vec_t mkv(input bit fv, input int addr, input bit p1, input bit p2,
                                 input bit fl, input int cnt, input int vld, input bit c1,
                                 input bit c2, input bit full, input bit ovf, input bit ca0,
                                 input int a0);
        vec_t v;
        v.fv = fv; v.addr = 31'(addr); v.p1 = p1; v.p2 = p2; v.fl = fl;
        v.e_cnt = cnt; v.e_vld = vld; v.e_c1 = c1; v.e_c2 = c2;
        v.e_full = full; v.e_ovf = ovf; v.ca0 = ca0; v.e_a0 = 31'(a0);
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit fv, input logic [30:0] a, input bit p1, input bit p2,
                         input bit fl);
        fetch_valid_f2  = fv;
        fetch_addr_f2   = a;
        fetch_data_f2   = data_of(a);
        fetch_fault_f2  = fault_of(a);
        align_pop1      = p1;
        align_pop2      = p2;
        exu_flush_final = fl;
    endtask

    task automatic chk_state(input string tag, input int cnt, input int vld, input bit c1,
                             input bit c2);
        chk({tag, ".count"}, 64'(fb_count), 64'(cnt));
        chk({tag, ".valid"}, 64'(fb_valid), 64'(vld));
        chk({tag, ".consume1"}, 64'(ifu_fb_consume1), 64'(c1));
        chk({tag, ".consume2"}, 64'(ifu_fb_consume2), 64'(c2));
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_state("reset", 0, 0, 1'b0, 1'b0);
        chk("reset.full", 64'(fb_full), 64'(0));
        chk("reset.overflow", 64'(fb_overflow), 64'(0));
        rst = 1'b0;
        mq.delete();
        movf = 1'b0;
    endtask

    // Reference: queue of blocks; consume and overflow derived from occupancy.
    task automatic model_step(input bit fv, input logic [30:0] a, input bit p1, input bit p2,
                              input bit fl);
        int n;
        int used;
        bit c1, c2;
        ent_t e;
        n  = mq.size();
        c2 = !fl && p2 && n >= 2;
        c1 = !fl && ((p2 && n == 1) || (p1 && !p2 && n >= 1));
        chk_state("rand", n, ((n >= 2) ? 2 : 0) + ((n >= 1) ? 1 : 0), c1, c2);
        chk("rand.full", 64'(fb_full), 64'(n == DEPTH));
        chk("rand.overflow", 64'(fb_overflow), 64'(movf));
        if (n >= 1) begin
            chk("rand.fb0_addr", 64'(fb0_addr), 64'(mq[0].addr));
            chk("rand.fb0_data", fb0_data, mq[0].data);
            chk("rand.fb0_fault", 64'(fb0_fault), 64'(mq[0].fault));
        end
        if (n >= 2) begin
            chk("rand.fb1_addr", 64'(fb1_addr), 64'(mq[1].addr));
            chk("rand.fb1_data", fb1_data, mq[1].data);
            chk("rand.fb1_fault", 64'(fb1_fault), 64'(mq[1].fault));
        end
        if (fl) begin
            mq.delete();
        end else begin
            used = c2 ? 2 : (c1 ? 1 : 0);
            for (int k = 0; k < used; k++) void'(mq.pop_front());
            if (fv) begin
                if (n < DEPTH || used > 0) begin
                    e.addr = a; e.data = data_of(a); e.fault = fault_of(a);
                    mq.push_back(e);
                end else begin
                    movf = 1'b1;
                end
            end
        end
    endtask

    initial begin
        //              fv addr    p1 p2 fl  cnt vld c1 c2 full ovf ca0 a0
        tbl[0]  = mkv(1, 'h40,  0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mkv(1, 'h48,  0, 0, 0,  1, 1, 0, 0, 0, 0, 1, 'h40);
        tbl[2]  = mkv(0, 0,     0, 0, 0,  2, 3, 0, 0, 0, 0, 1, 'h40);
        tbl[3]  = mkv(0, 0,     1, 0, 0,  2, 3, 1, 0, 0, 0, 1, 'h40);
        tbl[4]  = mkv(0, 0,     0, 1, 0,  1, 1, 1, 0, 0, 0, 1, 'h48);
        tbl[5]  = mkv(0, 0,     0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mkv(1, 'h100, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        tbl[7]  = mkv(1, 'h108, 0, 0, 0,  1, 1, 0, 0, 0, 0, 1, 'h100);
        tbl[8]  = mkv(1, 'h110, 0, 0, 0,  2, 3, 0, 0, 0, 0, 1, 'h100);
        tbl[9]  = mkv(1, 'h118, 0, 0, 0,  3, 3, 0, 0, 0, 0, 1, 'h100);
        tbl[10] = mkv(1, 'h120, 1, 0, 0,  4, 3, 1, 0, 1, 0, 1, 'h100);
        tbl[11] = mkv(0, 0,     0, 0, 0,  4, 3, 0, 0, 1, 0, 1, 'h108);
        tbl[12] = mkv(1, 'h128, 0, 0, 0,  4, 3, 0, 0, 1, 0, 1, 'h108);
        tbl[13] = mkv(0, 0,     0, 0, 0,  4, 3, 0, 0, 1, 1, 1, 'h108);
        tbl[14] = mkv(0, 0,     1, 0, 0,  4, 3, 1, 0, 1, 1, 1, 'h108);
        tbl[15] = mkv(0, 0,     1, 0, 0,  3, 3, 1, 0, 0, 1, 1, 'h110);
        tbl[16] = mkv(0, 0,     1, 0, 0,  2, 3, 1, 0, 0, 1, 1, 'h118);
        tbl[17] = mkv(0, 0,     1, 0, 0,  1, 1, 1, 0, 0, 1, 1, 'h120);
        tbl[18] = mkv(0, 0,     0, 0, 0,  0, 0, 0, 0, 0, 1, 0, 0);

        do_reset();
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            drive(tbl[i].fv, tbl[i].addr, tbl[i].p1, tbl[i].p2, tbl[i].fl);
            #1;
            chk_state($sformatf("tbl%0d", i), tbl[i].e_cnt, tbl[i].e_vld, tbl[i].e_c1,
                      tbl[i].e_c2);
            chk($sformatf("tbl%0d.full", i), 64'(fb_full), 64'(tbl[i].e_full));
            chk($sformatf("tbl%0d.overflow", i), 64'(fb_overflow), 64'(tbl[i].e_ovf));
            if (tbl[i].ca0) begin
                chk($sformatf("tbl%0d.fb0_addr", i), 64'(fb0_addr), 64'(tbl[i].e_a0));
                chk($sformatf("tbl%0d.fb0_data", i), fb0_data, data_of(tbl[i].e_a0));
            end
        end

        // Flush with a concurrent write and pop at count 3.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b1, 31'(32'h200 + 8 * i), 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk);
        drive(1'b1, 31'h230, 1'b1, 1'b0, 1'b1);
        #1;
        chk_state("flush.pre", 3, 3, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        #1;
        chk_state("flush.post", 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("flush.absent", 64'(fb_count), 64'(0));

        // Streaming write+pop1 for 20 blocks: pointers wrap, occupancy stays 1.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            drive(1'b1, 31'(32'h300 + 8 * k), 1'b1, 1'b0, 1'b0);
            #1;
            if (k == 0) begin
                chk_state("stream0", 0, 0, 1'b0, 1'b0);
            end else begin
                chk_state($sformatf("stream%0d", k), 1, 1, 1'b1, 1'b0);
                chk($sformatf("stream%0d.fb0_addr", k), 64'(fb0_addr),
                    64'(32'h300 + 8 * (k - 1)));
            end
        end
        @(negedge clk);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("stream.last_addr", 64'(fb0_addr), 64'(32'h300 + 8 * 19));
        chk("stream.last_count", 64'(fb_count), 64'(1));

        // Asynchronous reset mid-cycle with two blocks held.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(1'b1, 31'(32'h380 + 8 * i), 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        #1;
        chk_state("arst.pre", 2, 3, 1'b1, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_state("arst.async", 0, 0, 1'b0, 1'b0);
        chk("arst.full", 64'(fb_full), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 31'h400, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("arst.first_write_count", 64'(fb_count), 64'(1));
        chk("arst.first_write_addr", 64'(fb0_addr), 64'(32'h400));

        // Randomized traffic against the queue model.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            bit fv, p1, p2, fl;
            logic [30:0] a;
            if (c == 300) do_reset();
            @(negedge clk);
            fv = ($urandom_range(99) < 60);
            p1 = ($urandom_range(99) < 35);
            p2 = ($urandom_range(99) < 25);
            fl = ($urandom_range(99) < 3);
            a  = 31'($urandom);
            drive(fv, a, p1, p2, fl);
            #1;
            model_step(fv, a, p1, p2, fl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
